// File: rtl/seq_det_sched.sv
// -----------------------------------------------------------------------------
// seq_det_sched
//
// Two-requester round-robin front end feeding a "101" sequence counter.
// A granted frame is shifted MSB first through a non-overlapping Mealy
// detector for W cycles, then the match count is reported for one cycle.
//
// Ports
//   clk         : single clock, all state changes on its rising edge
//   reset       : synchronous, active-high reset
//   req0_valid  : requester 0 has a frame
//   req0_data   : requester 0 frame (W bits, MSB sent first)
//   req0_ready  : requester 0 frame accepted this cycle (combinational)
//   req1_valid  : requester 1 has a frame
//   req1_data   : requester 1 frame (W bits, MSB sent first)
//   req1_ready  : requester 1 frame accepted this cycle (combinational)
//   busy        : frame being shifted or reported
//   det_out     : Mealy detect pulse for the bit shifted this cycle
//   res_valid   : one-cycle result strobe
//   res_id      : requester owning the result
//   res_count   : number of "101" matches in the frame
// -----------------------------------------------------------------------------
module seq_det_sched #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_data,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_data,
  output logic         req1_ready,
  output logic         busy,
  output logic         det_out,
  output logic         res_valid,
  output logic         res_id,
  output logic [3:0]   res_count
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {S0, S1, S2} det_t;

  state_t        state_reg, state_next;
  det_t          det_reg, det_next;
  logic [W-1:0]  shift_reg, shift_next;
  logic [CW-1:0] bit_cnt_reg, bit_cnt_next;
  logic [3:0]    match_reg, match_next;
  logic          owner_reg, owner_next;
  // 1 means requester 1 was granted last, so requester 0 wins a tie next.
  logic          last_grant_reg, last_grant_next;
  logic          res_id_reg, res_id_next;
  logic [3:0]    res_count_reg, res_count_next;

  logic grant0, grant1;
  logic cur_bit;
  logic det_hit;

  // Grants are only offered in IDLE; they are masked while reset is held so
  // nothing can be accepted on the same edge that clears the block.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_reg == IDLE && !reset) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant_reg;
        grant1 = !last_grant_reg;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign cur_bit = shift_reg[W-1];
  assign det_hit = (state_reg == SHIFT) && (det_reg == S2) && cur_bit;

  always_comb begin
    state_next      = state_reg;
    det_next        = det_reg;
    shift_next      = shift_reg;
    bit_cnt_next    = bit_cnt_reg;
    match_next      = match_reg;
    owner_next      = owner_reg;
    last_grant_next = last_grant_reg;
    res_id_next     = res_id_reg;
    res_count_next  = res_count_reg;

    case (state_reg)
      IDLE: begin
        if (grant0 || grant1) begin
          shift_next      = grant1 ? req1_data : req0_data;
          owner_next      = grant1;
          last_grant_next = grant1;
          bit_cnt_next    = '0;
          match_next      = '0;
          det_next        = S0;
          state_next      = SHIFT;
        end
      end
      SHIFT: begin
        case (det_reg)
          S0:      det_next = cur_bit ? S1 : S0;
          S1:      det_next = cur_bit ? S1 : S2;
          S2:      det_next = S0;
          default: det_next = S0;
        endcase
        shift_next   = {shift_reg[W-2:0], 1'b0};
        match_next   = match_reg + {3'b000, det_hit};
        bit_cnt_next = bit_cnt_reg + CW'(1);
        if (bit_cnt_reg == LAST_BIT) begin
          // Result registers only change here, so they hold between frames.
          res_id_next    = owner_reg;
          res_count_next = match_reg + {3'b000, det_hit};
          state_next     = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      det_reg        <= S0;
      shift_reg      <= '0;
      bit_cnt_reg    <= '0;
      match_reg      <= '0;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      res_id_reg     <= 1'b0;
      res_count_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      det_reg        <= det_next;
      shift_reg      <= shift_next;
      bit_cnt_reg    <= bit_cnt_next;
      match_reg      <= match_next;
      owner_reg      <= owner_next;
      last_grant_reg <= last_grant_next;
      res_id_reg     <= res_id_next;
      res_count_reg  <= res_count_next;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign busy       = (state_reg != IDLE);
  assign det_out    = det_hit;
  assign res_valid  = (state_reg == DONE);
  assign res_id     = res_id_reg;
  assign res_count  = res_count_reg;

endmodule

// File: tb/tb_seq_det_sched.sv
// -----------------------------------------------------------------------------
// tb_seq_det_sched
//
// Drivers feed frames per requester from queues. A monitor keeps a timeline
// model (when the block is free, who wins a tie), pushes the expected result
// of every accepted frame into a scoreboard and pops it when res_valid shows.
// Expected counts and detect positions come from a greedy left-to-right scan
// of the frame for non-overlapping "101" substrings.
// -----------------------------------------------------------------------------
module tb_seq_det_sched;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_data, req1_data;
  logic         req0_ready, req1_ready;
  logic         busy, det_out, res_valid, res_id;
  logic [3:0]   res_count;

  seq_det_sched #(.W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .busy       (busy),
    .det_out    (det_out),
    .res_valid  (res_valid),
    .res_id     (res_id),
    .res_count  (res_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       id;
    logic [3:0] cnt;
    int         due;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  bit           rst_q    = 1'b0;
  int           sent0    = 0;
  int           sent1    = 0;
  bit           glitch1    = 1'b0;
  bit           glitch_on1 = 1'b0;

  task automatic chk(input string nm, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Greedy scan for non-overlapping "101"; mask marks the bit that completes
  // each match (aligned with data bit positions).
  task automatic ref_scan(input logic [W-1:0] d, output int cnt, output logic [W-1:0] mask);
    int i;
    cnt  = 0;
    mask = '0;
    i    = 0;
    while (i <= W - 3) begin
      if (d[W-1-i] && !d[W-2-i] && d[W-3-i]) begin
        cnt++;
        mask[W-3-i] = 1'b1;
        i += 3;
      end else begin
        i++;
      end
    end
  endtask

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  // ---------------------------------------------------------------- monitor
  initial begin
    int           free_at   = 0;
    bit           last_g    = 1'b1;
    int           cur_start = -1000;
    logic [W-1:0] cur_mask  = '0;
    logic         last_id   = 1'b0;
    logic [3:0]   last_cnt  = '0;
    forever begin
      @(negedge clk);
      if (rst_q) begin
        chk("reset_outputs", {busy, det_out, res_valid, res_id, res_count}, 0);
        if (reset) chk("reset_ready", {req1_ready, req0_ready}, 0);
        exp_q.delete();
        free_at   = cyc;
        last_g    = 1'b1;
        cur_start = -1000;
        last_id   = 1'b0;
        last_cnt  = '0;
      end
      if (!reset) begin
        bit   idle;
        int   expg;
        int   k;
        idle = (cyc >= free_at);
        chk("busy", busy, !idle);
        expg = 0;
        if (idle) begin
          if (req0_valid && req1_valid) expg = last_g ? 1 : 2;
          else if (req0_valid)          expg = 1;
          else if (req1_valid)          expg = 2;
        end
        chk("ready", {req1_ready, req0_ready}, expg);
        if (expg != 0) begin
          exp_t         e;
          int           c;
          logic [W-1:0] m;
          logic [W-1:0] d;
          d = (expg == 2) ? req1_data : req0_data;
          ref_scan(d, c, m);
          e.id  = (expg == 2);
          e.cnt = 4'(c);
          e.due = cyc + W + 1;
          exp_q.push_back(e);
          cur_start = cyc;
          cur_mask  = m;
          free_at   = cyc + W + 2;
          last_g    = (expg == 2);
        end
        k = cyc - cur_start - 1;
        if (k >= 0 && k < W) chk("det_out", det_out, cur_mask[W-1-k]);
        else                 chk("det_out_idle", det_out, 0);
        if (res_valid) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_res: got res_valid with id=%0d count=%0d, required none (cycle %0d)",
                     res_id, res_count, cyc);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("res_cycle", cyc, e.due);
            chk("res_id", res_id, e.id);
            chk("res_count", res_count, e.cnt);
            $display("result: cycle %0d id=%0d count=%0d", cyc, res_id, res_count);
            last_id  = e.id;
            last_cnt = e.cnt;
          end
        end else begin
          chk("res_id_hold", res_id, last_id);
          chk("res_count_hold", res_count, last_cnt);
        end
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  initial begin
    bit acc;
    req0_valid = 1'b0;
    req0_data  = '0;
    forever begin
      @(negedge clk);
      acc = req0_valid && req0_ready && !reset;
      @(posedge clk);
      #1;
      if (acc) begin
        req0_valid = 1'b0;
        sent0++;
      end
      if (!req0_valid && q0.size() > 0) begin
        req0_data  = q0.pop_front();
        req0_valid = 1'b1;
      end
    end
  end

  // Requester 1 can also raise a one-cycle "glitch" request that is withdrawn
  // if not granted, to show that an ungranted valid leaves no trace.
  initial begin
    bit acc;
    req1_valid = 1'b0;
    req1_data  = '0;
    forever begin
      @(negedge clk);
      acc = req1_valid && req1_ready && !reset;
      @(posedge clk);
      #1;
      if (acc) begin
        req1_valid = 1'b0;
        glitch_on1 = 1'b0;
        sent1++;
      end else if (glitch_on1) begin
        req1_valid = 1'b0;
        glitch_on1 = 1'b0;
      end
      if (!req1_valid) begin
        if (glitch1) begin
          req1_data  = W'($urandom);
          req1_valid = 1'b1;
          glitch1    = 1'b0;
          glitch_on1 = 1'b1;
        end else if (q1.size() > 0) begin
          req1_data  = q1.pop_front();
          req1_valid = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic wait_idle();
    int n = 0;
    while (!(q0.size() == 0 && q1.size() == 0 && !req0_valid && !req1_valid &&
             !glitch1 && !glitch_on1 && exp_q.size() == 0)) begin
      @(negedge clk);
      n++;
      if (n > 1000) begin
        n_checks++;
        n_fail++;
        $display("FAIL wait_idle: still %0d results pending after %0d cycles, required 0", exp_q.size(), n);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sent0(input int s);
    int n = 0;
    while (sent0 == s) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL wait_grant0: sent0 stayed %0d, required %0d", sent0, s + 1);
        break;
      end
    end
  endtask

  initial begin
    int s;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Basic frames, including repeated-1 and all-same patterns.
    q0.push_back(8'b1010_1010); wait_idle();
    q1.push_back(8'b1101_0000); wait_idle();
    q0.push_back(8'hFF); q0.push_back(8'h00); wait_idle();

    // Both requesters busy right after reset: grants alternate 0,1,0,1.
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    q0.push_back(W'($urandom)); q0.push_back(W'($urandom));
    q1.push_back(W'($urandom)); q1.push_back(W'($urandom));
    wait_idle();

    // Reset during bit 4 of a frame that is in S2 by then; the next frame
    // would produce a false detect if detector state leaked.
    s = sent0;
    q0.push_back(8'b1101_1111);
    wait_sent0(s);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    q0.push_back(8'b1000_0000);
    wait_idle();

    // Ungranted request on requester 1 while busy is ignored.
    s = sent0;
    q0.push_back(8'b0101_0101);
    wait_sent0(s);
    glitch1 = 1'b1;
    wait_idle();

    // Back-to-back: first ends in S1, second would match if state carried.
    q0.push_back(8'b0000_0001); q0.push_back(8'b0100_0000);
    wait_idle();

    // Randomised traffic.
    for (int n = 0; n < 60; n++) begin
      int r;
      r = $urandom_range(0, 3);
      case (r)
        0: q0.push_back(W'($urandom));
        1: q1.push_back(W'($urandom));
        2: begin
          q0.push_back(W'($urandom));
          q1.push_back(W'($urandom));
        end
        default: begin
          q0.push_back(W'($urandom));
          if (!glitch1 && !glitch_on1) glitch1 = 1'b1;
        end
      endcase
      if ($urandom_range(0, 1) == 0) wait_idle();
      else repeat ($urandom_range(0, 5)) @(posedge clk);
    end
    wait_idle();
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
